ex_muldiv_unit: RTL

- Execute-stage multiply/divide unit directly downstream of the ID/EX pipeline register.
- Consumes EX_ALUOp plus the forwarded EX operands, and owns the architectural HI/LO registers.
- Runs multi-cycle MULT/DIV operations in the background.
- Raises a stall request to the hazard unit when a younger HI/LO access or a new mul/div op collides with an in-flight operation.

---
 rtl/cpu_pkg.sv | 60 ++++++
 rtl/muldiv_divider.sv | 65 ++++++
 rtl/ex_muldiv_unit.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU package: ALUOp codes for the mul/div unit, its FSM state
// type, divider defaults and op-class helpers. Optional MULDIV_MADD_EN.
package cpu_pkg;

    localparam int XLEN         = 32;
    localparam int DIV_ITER_DEF = 32;

    localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

    localparam logic [4:0] ALU_NOP   = 5'h00;
    localparam logic [4:0] ALU_MULT  = 5'h10;
    localparam logic [4:0] ALU_MULTU = 5'h11;
    localparam logic [4:0] ALU_DIV   = 5'h12;
    localparam logic [4:0] ALU_DIVU  = 5'h13;
    localparam logic [4:0] ALU_MFHI  = 5'h14;
    localparam logic [4:0] ALU_MFLO  = 5'h15;
    localparam logic [4:0] ALU_MTHI  = 5'h16;
    localparam logic [4:0] ALU_MTLO  = 5'h17;
    localparam logic [4:0] ALU_MADD  = 5'h18;
    localparam logic [4:0] ALU_MADDU = 5'h19;
    localparam logic [4:0] ALU_MSUB  = 5'h1A;
    localparam logic [4:0] ALU_MSUBU = 5'h1B;

    typedef enum logic [1:0] {
        MD_IDLE    = 2'd0,
        MD_MUL     = 2'd1,
        MD_DIV     = 2'd2,
        MD_DIV_FIX = 2'd3
    } md_state_e;

    // Ops that occupy the multiplier for MUL_CYCLES.
    function automatic logic is_mul_op(input logic [4:0] op);
`ifdef MULDIV_MADD_EN
        return (op == ALU_MULT)  || (op == ALU_MULTU) ||
               (op == ALU_MADD)  || (op == ALU_MADDU) ||
               (op == ALU_MSUB)  || (op == ALU_MSUBU);
`else
        return (op == ALU_MULT) || (op == ALU_MULTU);
`endif
    endfunction

    function automatic logic is_div_op(input logic [4:0] op);
        return (op == ALU_DIV) || (op == ALU_DIVU);
    endfunction

    function automatic logic is_hilo_op(input logic [4:0] op);
        return (op == ALU_MFHI) || (op == ALU_MFLO) ||
               (op == ALU_MTHI) || (op == ALU_MTLO);
    endfunction

    // Every op this unit reacts to; all of them stall while busy.
    function automatic logic is_md_op(input logic [4:0] op);
        return is_mul_op(op) || is_div_op(op) || is_hilo_op(op);
    endfunction

    function automatic logic is_signed_mul(input logic [4:0] op);
        return (op == ALU_MULT) || (op == ALU_MADD) || (op == ALU_MSUB);
    endfunction

endpackage

// File: rtl/muldiv_divider.sv
// Iterative radix-2 restoring divider on unsigned magnitudes.
// Ports: CLK/RST, start + dividend/divisor in, done pulse, raw quotient/remainder out.
module muldiv_divider #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    logic [W-1:0]  quo_q;
    logic [W-1:0]  rem_q;
    logic [W-1:0]  dvs_q;
    logic [CW-1:0] cnt_q;
    logic          run_q;

    logic [W:0]    sh;
    logic [W-1:0]  diff;
    logic          ge;

    // One restoring step: shift in the next dividend bit and try a subtract.
    // The remainder always stays below the divisor, so the low W bits of
    // the difference are exact whenever the subtract is taken.
    always_comb begin
        sh   = {rem_q, quo_q[W-1]};
        ge   = (sh >= {1'b0, dvs_q});
        diff = sh[W-1:0] - dvs_q;
    end

    assign done      = run_q && (cnt_q == LAST);
    assign quotient  = quo_q;
    assign remainder = rem_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            quo_q <= dividend;
            rem_q <= '0;
            dvs_q <= divisor;
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (run_q) begin
            quo_q <= {quo_q[W-2:0], ge};
            rem_q <= ge ? diff : sh[W-1:0];
            cnt_q <= cnt_q + 1'b1;
            if (done) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit owning HI/LO; multi-cycle MULT/DIV with stall
// request. Ports: CLK, RST (async low), EX_ALUOp, EX_ReadData1/2, M_Stall,
// EX_Flush in; EX_MulDivStall, EX_MulDivResult, EX_MulDivBusy out.
// Optional MADD/MADDU/MSUB/MSUBU accumulate ops under `define MULDIV_MADD_EN.
module ex_muldiv_unit
    import cpu_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_ITER   = DIV_ITER_DEF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [4:0]  EX_ALUOp,
    input  logic [31:0] EX_ReadData1,
    input  logic [31:0] EX_ReadData2,
    input  logic        M_Stall,
    input  logic        EX_Flush,
    output logic        EX_MulDivStall,
    output logic [31:0] EX_MulDivResult,
    output logic        EX_MulDivBusy
);

    localparam int MCW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [MCW-1:0] MUL_LAST = MCW'(MUL_CYCLES - 1);

    md_state_e      state_q;
    md_state_e      state_d;
    logic [MCW-1:0] cnt_q;
    logic [MCW-1:0] cnt_d;

    logic [4:0]     op_q;
    logic [31:0]    rs_q;
    logic [31:0]    rt_q;
    logic [31:0]    hi_q;
    logic [31:0]    lo_q;
    logic [31:0]    hi_d;
    logic [31:0]    lo_d;

    logic           md_op;
    logic           issue;
    logic           start_mul;
    logic           start_div;

    // Issue control. The stall is purely busy & op so a held op is never
    // issued twice: it can only issue once the unit has returned to idle.
    assign md_op          = is_md_op(EX_ALUOp);
    assign EX_MulDivBusy  = (state_q != MD_IDLE);
    assign EX_MulDivStall = EX_MulDivBusy & md_op;
    assign issue          = md_op & ~M_Stall & ~EX_Flush & ~EX_MulDivStall;
    assign start_mul      = issue & is_mul_op(EX_ALUOp);
    assign start_div      = issue & is_div_op(EX_ALUOp);

    // Divider is fed magnitudes; signs are restored in DIV_FIX.
    logic        sdiv_in;
    logic [31:0] dvd_mag;
    logic [31:0] dvs_mag;
    logic        div_done;
    logic [31:0] div_quo;
    logic [31:0] div_rem;

    always_comb begin
        sdiv_in = (EX_ALUOp == ALU_DIV);
        dvd_mag = (sdiv_in & EX_ReadData1[31]) ? (~EX_ReadData1 + 32'd1)
                                               : EX_ReadData1;
        dvs_mag = (sdiv_in & EX_ReadData2[31]) ? (~EX_ReadData2 + 32'd1)
                                               : EX_ReadData2;
    end

    muldiv_divider #(
        .W (DIV_ITER)
    ) u_div (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start_div),
        .dividend  (dvd_mag),
        .divisor   (dvs_mag),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Multiply on latched operands; evaluated on the last MUL cycle.
    logic        mul_signed;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] prod;
    logic [63:0] mul_res;

    always_comb begin
        mul_signed = is_signed_mul(op_q);
        mul_a = mul_signed ? {{32{rs_q[31]}}, rs_q} : {32'b0, rs_q};
        mul_b = mul_signed ? {{32{rt_q[31]}}, rt_q} : {32'b0, rt_q};
        prod  = mul_a * mul_b;
`ifdef MULDIV_MADD_EN
        unique case (1'b1)
            (op_q == ALU_MADD) || (op_q == ALU_MADDU):
                mul_res = {hi_q, lo_q} + prod;
            (op_q == ALU_MSUB) || (op_q == ALU_MSUBU):
                mul_res = {hi_q, lo_q} - prod;
            default:
                mul_res = prod;
        endcase
`else
        mul_res = prod;
`endif
    end

    // Divide sign fix-up and the divide-by-zero override.
    logic        div_signed;
    logic        q_neg;
    logic        r_neg;
    logic [31:0] div_lo;
    logic [31:0] div_hi;

    always_comb begin
        div_signed = (op_q == ALU_DIV);
        q_neg      = div_signed & (rs_q[31] ^ rt_q[31]);
        r_neg      = div_signed & rs_q[31];
        if (rt_q == 32'd0) begin
            div_lo = DIV0_QUOTIENT;
            div_hi = rs_q;
        end else begin
            div_lo = q_neg ? (~div_quo + 32'd1) : div_quo;
            div_hi = r_neg ? (~div_rem + 32'd1) : div_rem;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            MD_IDLE: begin
                cnt_d = '0;
                if (start_mul) begin
                    state_d = MD_MUL;
                end else if (start_div) begin
                    state_d = MD_DIV;
                end
            end
            MD_MUL: begin
                if (cnt_q == MUL_LAST) begin
                    state_d = MD_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            MD_DIV: begin
                if (div_done) begin
                    state_d = MD_DIV_FIX;
                end
            end
            MD_DIV_FIX: begin
                state_d = MD_IDLE;
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // HI/LO writes. MT ops only issue when idle, so they never collide
    // with a completing multiply or divide.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (issue && (EX_ALUOp == ALU_MTHI)) begin
            hi_d = EX_ReadData1;
        end
        if (issue && (EX_ALUOp == ALU_MTLO)) begin
            lo_d = EX_ReadData1;
        end
        if ((state_q == MD_MUL) && (cnt_q == MUL_LAST)) begin
            hi_d = mul_res[63:32];
            lo_d = mul_res[31:0];
        end
        if (state_q == MD_DIV_FIX) begin
            hi_d = div_hi;
            lo_d = div_lo;
        end
    end

    always_comb begin
        EX_MulDivResult = 32'd0;
        if (EX_ALUOp == ALU_MFHI) begin
            EX_MulDivResult = hi_q;
        end else if (EX_ALUOp == ALU_MFLO) begin
            EX_MulDivResult = lo_q;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            op_q    <= ALU_NOP;
            rs_q    <= '0;
            rt_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            if (start_mul | start_div) begin
                op_q <= EX_ALUOp;
                rs_q <= EX_ReadData1;
                rt_q <= EX_ReadData2;
            end
        end
    end

endmodule
